// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises instruction-fetch and load/store accesses onto a byte-wide single-port RAM
module mem_ctrl #(
  parameter int ADR_W = 17,
  parameter int DAT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ic_en_i,
  input  logic [ADR_W-1:0] ic_pc_i,
  output logic             ic_en_o,
  output logic [DAT_W-1:0] ic_ins_o,
  input  logic             lsb_en_i,
  input  logic             lsb_wr_i,
  input  logic [1:0]       lsb_len_i,
  input  logic [ADR_W-1:0] lsb_adr_i,
  input  logic [DAT_W-1:0] lsb_dat_i,
  output logic             lsb_en_o,
  output logic [DAT_W-1:0] lsb_dat_o,
  input  logic [7:0]       ram_din_i,
  output logic [7:0]       ram_dout_o,
  output logic [ADR_W-1:0] ram_a_o,
  output logic             ram_wr_o
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state;
  logic ic_pend, lsb_pend, lsb_wr, src_lsb, wr_q, stall_q;
  logic [1:0] lsb_len;
  logic [ADR_W-1:0] ic_pc, lsb_adr, base;
  logic [DAT_W-1:0] lsb_dat, dat;
  logic [DAT_W-9:0] sh;
  logic [2:0] n, cnt;
  logic l_req, i_req, l_wr;
  logic [1:0] l_len;
  logic [2:0] l_n;
  logic [ADR_W-1:0] l_adr, i_pc;
  logic [DAT_W-1:0] l_dat;
  // effective request view: a request arriving on this edge is eligible and overrides latched fields
  always_comb begin
    l_req = lsb_en_i | lsb_pend;
    i_req = ic_en_i | ic_pend;
    l_wr  = lsb_en_i ? lsb_wr_i : lsb_wr;
    l_len = lsb_en_i ? lsb_len_i : lsb_len;
    l_adr = lsb_en_i ? lsb_adr_i : lsb_adr;
    l_dat = lsb_en_i ? lsb_dat_i : lsb_dat;
    i_pc  = ic_en_i ? ic_pc_i : ic_pc;
    l_n   = l_len == 2'd0 ? 3'd1 : l_len == 2'd1 ? 3'd2 : 3'd4;
  end
  // the write strobe is gated by en so a frozen block never writes
  assign ram_wr_o = wr_q & en;
  // remembers whether the previous edge was frozen so an interrupted read can restart
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_q <= 1'b0;
    else stall_q <= !en;
  // request latching, arbitration and byte-serial read/write sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ic_pend    <= 1'b0;
      lsb_pend   <= 1'b0;
      ic_pc      <= '0;
      lsb_wr     <= 1'b0;
      lsb_len    <= '0;
      lsb_adr    <= '0;
      lsb_dat    <= '0;
      src_lsb    <= 1'b0;
      base       <= '0;
      n          <= '0;
      cnt        <= '0;
      dat        <= '0;
      sh         <= '0;
      wr_q       <= 1'b0;
      ic_en_o    <= 1'b0;
      ic_ins_o   <= '0;
      lsb_en_o   <= 1'b0;
      lsb_dat_o  <= '0;
      ram_dout_o <= '0;
      ram_a_o    <= '0;
    end else if (en) begin
      ic_en_o  <= 1'b0;
      lsb_en_o <= 1'b0;
      if (ic_en_i) begin
        ic_pend <= 1'b1;
        ic_pc   <= ic_pc_i;
      end
      if (lsb_en_i) begin
        lsb_pend <= 1'b1;
        lsb_wr   <= lsb_wr_i;
        lsb_len  <= lsb_len_i;
        lsb_adr  <= lsb_adr_i;
        lsb_dat  <= lsb_dat_i;
      end
      if (state == IDLE) begin
        if (l_req) begin
          lsb_pend <= 1'b0;
          src_lsb  <= 1'b1;
          base     <= l_adr;
          n        <= l_n;
          cnt      <= 3'd1;
          ram_a_o  <= l_adr;
          if (l_wr) begin
            state      <= WRITE;
            wr_q       <= 1'b1;
            ram_dout_o <= l_dat[7:0];
            dat        <= l_dat >> 8;
          end else
            state <= READ;
        end else if (i_req) begin
          ic_pend <= 1'b0;
          src_lsb <= 1'b0;
          base    <= i_pc;
          n       <= 3'd4;
          cnt     <= 3'd1;
          ram_a_o <= i_pc;
          state   <= READ;
        end
      end else if (state == READ) begin
        if (stall_q) begin
          ram_a_o <= base;
          cnt     <= 3'd1;
        end else begin
          cnt <= cnt + 3'd1;
          if (cnt < n) ram_a_o <= base + ADR_W'(cnt);
          if (cnt >= 3'd2 && cnt <= n) sh <= {ram_din_i, sh[DAT_W-9:8]};
          if (cnt == n + 3'd1) begin
            state <= IDLE;
            if (src_lsb) begin
              lsb_en_o  <= 1'b1;
              lsb_dat_o <= n == 3'd1 ? {{(DAT_W-8){1'b0}}, ram_din_i} :
                           n == 3'd2 ? {{(DAT_W-16){1'b0}}, ram_din_i, sh[DAT_W-9 -: 8]} :
                                       {ram_din_i, sh};
            end else begin
              ic_en_o  <= 1'b1;
              ic_ins_o <= {ram_din_i, sh};
            end
          end
        end
      end else begin
        cnt <= cnt + 3'd1;
        if (cnt < n) begin
          ram_a_o    <= base + ADR_W'(cnt);
          ram_dout_o <= dat[7:0];
          dat        <= dat >> 8;
        end else begin
          wr_q     <= 1'b0;
          lsb_en_o <= 1'b1;
          state    <= IDLE;
        end
      end
    end
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the 32-bit core and the byte-wide, single-port unified RAM. It serves instruction-fetch misses from the instruction cache and data loads/stores from the load-store buffer (LSB). Each access is serialised into 1, 2 or 4 byte-cycles. Results go back to the requester as a one-cycle done pulse.

## Interface
- ADR_W, 17: RAM byte-address width.
- DAT_W, 32: instruction/data word width.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global ready; 0 freezes the block.
- ic_en_i  in  1  one-cycle fetch request from instruction cache.
- ic_pc_i  in  ADR_W  fetch address; sampled only when ic_en_i=1.
- ic_en_o  out  1  one-cycle fetch-done pulse.
- ic_ins_o  out  DAT_W  fetched word, little-endian.
- lsb_en_i  in  1  one-cycle data request.
- lsb_wr_i  in  1  1 = store, 0 = load.
- lsb_len_i  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- lsb_adr_i  in  ADR_W  data byte address.
- lsb_dat_i  in  DAT_W  store data; low bytes are used.
- lsb_en_o  out  1  one-cycle load/store-done pulse.
- lsb_dat_o  out  DAT_W  load data, zero-extended.
- ram_din_i  in  8  RAM read byte.
- ram_dout_o  out  8  RAM write byte.
- ram_a_o  out  ADR_W  RAM byte address.
- ram_wr_o  out  1  1 = write, 0 = read.

## Operation
- All outputs are registered. Reset value of every output is 0. On reset, the state goes to IDLE and both pending flags are cleared.
- **Request latching**
  - ic_en_i sets ic_pend and latches ic_pc_i.
  - lsb_en_i sets lsb_pend and latches wr, len, adr and dat.
  - Requests are latched on any edge with en=1, including while busy.
  - Each source has at most one request outstanding. A second request from a source that is already pending overwrites the latched fields.
- **Arbitration in IDLE**
  - lsb_pend wins over ic_pend.
  - A request arriving on the same edge is eligible on that edge, so the grant can be combinational from the pending flags OR the inputs.
  - The pending flag of the granted source clears on grant.
- **Byte count N:** an ic request is 4. An lsb request is 1, 2 or 4 from len.
- **Address arithmetic:** byte k goes to base+k modulo 2^ADR_W, so addresses wrap past the top.
- **States:** IDLE, READ, WRITE.
- **READ**
  - Edge E0 (grant): ram_a_o<=base, ram_wr_o<=0.
  - Edges E1..E(N-1): ram_a_o<=base+k.
  - ram_din_i during the cycle after E(k+1) is the byte for address base+k. It is captured at edge E(k+2) into byte lane k.
  - At edge E(N+1) the last byte is captured directly into the result register, and the done pulse for that source goes to 1.
  - The state returns to IDLE at E(N+1).
  - Unused upper lanes of lsb_dat_o are 0.
  - After the last address, ram_a_o holds its value.
- **WRITE**
  - Edges E0..E(N-1): ram_wr_o<=1, ram_a_o<=base+k, ram_dout_o<=dat[8k+7:8k].
  - At edge E(N): ram_wr_o<=0, lsb_en_o<=1, state returns to IDLE.
- **Done pulses and result registers:** done pulses are high for exactly one cycle. ic_ins_o and lsb_dat_o hold their value until the next completion from the same source.
- **en=0:** all registers hold, requests are not latched, and ram_wr_o is forced to 0.
  - If en drops during READ, the read restarts from byte 0 at the first edge with en=1.
  - If en drops during WRITE, the write resumes at the next byte not yet written.

## Timing
- Word fetch: ic_en_i is high in cycle c0 with the block idle, and ic_en_o is high in cycle c5. Latency is N+1 edges.
- Load of N bytes: done after N+1 edges. Store of N bytes: done after N edges.
- The earliest next grant is the edge after the done edge, so back-to-back word fetches take 6 cycles each, with no bubble beyond the IDLE cycle.
- A request arriving on the same edge as the other source's done edge is latched and served next.
- Asynchronous reset mid-transaction: outputs go to 0 immediately, with no done pulse. Any partial store stays in RAM.

## Test plan
- **Word fetch:** RAM[0x100..0x103]=13,05,00,00. Pulse ic_en_i with pc=0x100. Required response:
  - ic_en_o high exactly 5 cycles later, for one cycle.
  - ic_ins_o=0x00000513.
  - ram_a_o sequence 0x100..0x103.
  - ram_wr_o always 0.
- **Byte/half store:** lsb wr=1, len=1, adr=0x2000, dat=0xDEADBEEF. Required response:
  - RAM writes EF@0x2000, then BE@0x2001.
  - lsb_en_o high 2 cycles after the request.
  - RAM[0x2002] untouched.
- **Simultaneous requests:** ic_en_i and lsb_en_i (load word, adr=0x40) on the same edge. Required response:
  - The LSB load is served first.
  - lsb_en_o after 5 cycles.
  - ic_en_o after a further 6 cycles, with the correct word.
- **Wrap-around:** half load at adr=0x1FFFF with RAM[0x1FFFF]=AA and RAM[0x0]=BB. Required response:
  - ram_a_o sequence 0x1FFFF, 0x00000.
  - lsb_dat_o=0x0000BBAA.
- **Reset mid-store:** assert rst after the 2nd byte of a word store. Required response:
  - All outputs 0 immediately, no lsb_en_o.
  - After reset release, an ic fetch completes normally in 5 cycles.
- **en stall:** drop en for 3 cycles during a word fetch. Required response:
  - No RAM writes occur.
  - The fetch restarts from byte 0 and returns the correct word 5 cycles after en returns.
